// File: rtl/ddr_maint_cmd_pkg.sv
// Shared definitions for the DDR4 maintenance command sequencer: FSM states,
// command-pin encodings, default timing and address-bus width.
package ddr_maint_cmd_pkg;

    typedef enum logic [2:0] {
        M_IDLE,
        M_PREA,
        M_TRP,
        M_REF,
        M_TRFC,
        M_MRS,
        M_TMOD
    } maint_fsm_type;

    // Address bus / MR payload width (A10 must exist for PREA)
    localparam int MRS_WIDTH = 14;

    // Default command spacing in clock cycles
    localparam int tRP  = 4;
    localparam int tRFC = 12;
    localparam int tMOD = 6;

    // Command pin encodings, ordered {cs_n, act_n, ras_n, cas_n, we_n}
    localparam logic [4:0] CMD_NOP  = 5'b11111;
    localparam logic [4:0] CMD_PREA = 5'b01010;
    localparam logic [4:0] CMD_REF  = 5'b01001;
    localparam logic [4:0] CMD_MRS  = 5'b01000;

    // A10 high selects all banks on a precharge
    localparam logic [MRS_WIDTH-1:0] ADDR_A10 = MRS_WIDTH'(1024);

endpackage

// File: rtl/ddr_maint_timer.sv
// Loadable down-counter shared by the tRP, tRFC and tMOD wait states.
// done is high for the single cycle in which the count equals 1, so a load of
// N yields exactly N wait cycles before the owning FSM moves on.
module ddr_maint_timer #(
    parameter int W = 4
) (
    input  logic         clock_t,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load a new wait length or count down towards zero
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/ddr_maint_cmd.sv
// DDR4 maintenance command sequencer: tracks outstanding read/write traffic,
// and once traffic is drained issues PREA followed by REF or MRS, honouring
// tRP, tRFC and tMOD. Refresh always wins over a pending mode-register write.
module ddr_maint_cmd
    import ddr_maint_cmd_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int T_RP    = tRP,
    parameter int T_RFC   = tRFC,
    parameter int T_MOD_P = tMOD
) (
    input  logic                 clock_t,
    input  logic                 reset_n,
    input  logic                 rw_proc,
    input  logic                 refresh_rdy,
    input  logic                 mrs_update_rdy,
    input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
    input  logic                 rw_issue,
    input  logic                 rw_retire,
    output logic                 rw_idle,
    output logic                 maint_busy,
    output logic                 cs_n,
    output logic                 act_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [1:0]           bg,
    output logic [1:0]           ba,
    output logic [MRS_WIDTH-1:0] addr,
    output logic                 err_underflow
);

    localparam int T_MAX = (T_RFC > T_MOD_P) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                             : ((T_MOD_P > T_RP) ? T_MOD_P : T_RP);
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    maint_fsm_type        state;
    logic [CNT_W-1:0]     cnt;
    logic                 pend_ref;
    logic                 pend_mrs;
    logic [MRS_WIDTH-1:0] mrs_payload;
    logic [4:0]           cmd_q;
    logic                 go;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_done;

    assign go = (pend_ref || pend_mrs) && !rw_proc && (cnt == '0);

    assign {cs_n, act_n, ras_n, cas_n, we_n} = cmd_q;
    // PREA is all-bank and MRS always targets MR0, so bank selects stay zero
    assign bg = 2'b00;
    assign ba = 2'b00;

    // Outstanding transaction count, drained-traffic flag and sticky error
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            err_underflow <= 1'b0;
            rw_idle       <= 1'b0;
        end else begin
            if (rw_issue && !rw_retire) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else if (rw_retire && !rw_issue) begin
                if (cnt == '0) err_underflow <= 1'b1;
                else           cnt <= cnt - 1'b1;
            end
            if (rw_issue && maint_busy) err_underflow <= 1'b1;
            rw_idle <= !rw_proc && (cnt == '0) && (state == M_IDLE);
        end
    end

    // MR payload is plain data captured with its request strobe
    always_ff @(posedge clock_t) begin
        if (mrs_update_rdy) mrs_payload <= mrs_update_cmd;
    end

    // Arm the shared timer as each command leaves the pins
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            M_PREA: begin tmr_load = 1'b1; tmr_val = TMR_W'(T_RP - 1);    end
            M_REF:  begin tmr_load = 1'b1; tmr_val = TMR_W'(T_RFC - 1);   end
            M_MRS:  begin tmr_load = 1'b1; tmr_val = TMR_W'(T_MOD_P - 1); end
            default: ;
        endcase
    end

    ddr_maint_timer #(.W(TMR_W)) u_timer (
        .clock_t  (clock_t),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Sequencer: registered pins always carry the command of the state being entered
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state      <= M_IDLE;
            cmd_q      <= CMD_NOP;
            addr       <= '0;
            maint_busy <= 1'b0;
            pend_ref   <= 1'b0;
            pend_mrs   <= 1'b0;
        end else begin
            cmd_q      <= CMD_NOP;
            addr       <= '0;
            maint_busy <= 1'b1;
            pend_ref   <= pend_ref | refresh_rdy;
            pend_mrs   <= pend_mrs | mrs_update_rdy;
            case (state)
                M_IDLE: begin
                    if (go) begin
                        state <= M_PREA;
                        cmd_q <= CMD_PREA;
                        addr  <= ADDR_A10;
                    end else begin
                        maint_busy <= 1'b0;
                    end
                end
                M_PREA: state <= M_TRP;
                M_TRP: begin
                    // Requests are cleared as they are issued; a strobe in the
                    // same cycle re-arms them for a later sequence
                    if (tmr_done) begin
                        if (pend_ref) begin
                            state    <= M_REF;
                            cmd_q    <= CMD_REF;
                            pend_ref <= refresh_rdy;
                        end else begin
                            state    <= M_MRS;
                            cmd_q    <= CMD_MRS;
                            addr     <= mrs_payload;
                            pend_mrs <= mrs_update_rdy;
                        end
                    end
                end
                M_REF: state <= M_TRFC;
                M_TRFC: begin
                    if (tmr_done) begin
                        state      <= M_IDLE;
                        maint_busy <= 1'b0;
                    end
                end
                M_MRS: state <= M_TMOD;
                M_TMOD: begin
                    if (tmr_done) begin
                        state      <= M_IDLE;
                        maint_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= M_IDLE;
                    maint_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_maint_cmd.sv
// Randomised and directed bench for ddr_maint_cmd against a timeline-based
// reference model (sequence offset from PREA, plain integer counters).
module tb_ddr_maint_cmd;
    import ddr_maint_cmd_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clock_t = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 rw_proc = 1'b0;
    logic                 refresh_rdy = 1'b0;
    logic                 mrs_update_rdy = 1'b0;
    logic [MRS_WIDTH-1:0] mrs_update_cmd = '0;
    logic                 rw_issue = 1'b0;
    logic                 rw_retire = 1'b0;
    logic                 rw_idle, maint_busy, cs_n, act_n, ras_n, cas_n, we_n, err_underflow;
    logic [1:0]           bg, ba;
    logic [MRS_WIDTH-1:0] addr;

    ddr_maint_cmd #(.CNT_W(CNT_W)) dut (
        .clock_t        (clock_t),
        .reset_n        (reset_n),
        .rw_proc        (rw_proc),
        .refresh_rdy    (refresh_rdy),
        .mrs_update_rdy (mrs_update_rdy),
        .mrs_update_cmd (mrs_update_cmd),
        .rw_issue       (rw_issue),
        .rw_retire      (rw_retire),
        .rw_idle        (rw_idle),
        .maint_busy     (maint_busy),
        .cs_n           (cs_n),
        .act_n          (act_n),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .bg             (bg),
        .ba             (ba),
        .addr           (addr),
        .err_underflow  (err_underflow)
    );

    always #5 clock_t = ~clock_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: timeline of the current sequence measured from PREA
    int                   m_cnt;
    bit                   m_err, m_pref, m_pmrs, m_active, m_idle, m_kind_ref;
    int                   m_off;
    logic [MRS_WIDTH-1:0] m_pl;
    logic [4:0]           m_cmd;
    logic [MRS_WIDTH-1:0] m_addr;

    // Observed command log
    logic [4:0]           log_cmd[$];
    int                   log_cyc[$];
    logic [MRS_WIDTH-1:0] log_addr[$];
    int                   cyc = 0;
    int                   fall_cyc = 0;
    bit                   prev_busy = 1'b0;

    task automatic model_reset();
        m_cnt = 0; m_err = 0; m_pref = 0; m_pmrs = 0; m_active = 0; m_idle = 0;
        m_kind_ref = 0; m_off = 0; m_pl = '0; m_cmd = CMD_NOP; m_addr = '0;
    endtask

    task automatic model_step();
        bit pre_active, pre_pref;
        int pre_cnt;
        logic [MRS_WIDTH-1:0] pre_pl;
        if (!reset_n) begin
            model_reset();
            return;
        end
        pre_active = m_active; pre_cnt = m_cnt; pre_pref = m_pref; pre_pl = m_pl;
        m_idle = !rw_proc && pre_cnt == 0 && !pre_active;
        if (rw_issue && pre_active) m_err = 1;
        if (rw_issue && !rw_retire) m_cnt = (pre_cnt < CMAX) ? pre_cnt + 1 : CMAX;
        else if (rw_retire && !rw_issue) begin
            if (pre_cnt == 0) m_err = 1;
            else m_cnt = pre_cnt - 1;
        end
        m_cmd = CMD_NOP; m_addr = '0;
        if (!pre_active) begin
            if ((m_pref || m_pmrs) && !rw_proc && pre_cnt == 0) begin
                m_active = 1; m_off = 0; m_cmd = CMD_PREA; m_addr = ADDR_A10;
            end
        end else begin
            m_off++;
            if (m_off == tRP) begin
                m_kind_ref = pre_pref;
                if (pre_pref) begin m_cmd = CMD_REF; m_pref = 0; end
                else begin m_cmd = CMD_MRS; m_addr = pre_pl; m_pmrs = 0; end
            end
            if (m_off > tRP && m_off == tRP + (m_kind_ref ? tRFC : tMOD)) m_active = 0;
        end
        if (refresh_rdy) m_pref = 1;
        if (mrs_update_rdy) begin m_pmrs = 1; m_pl = mrs_update_cmd; end
    endtask

    task automatic cycle();
        logic [4:0] pins;
        @(posedge clock_t);
        cyc++;
        model_step();
        #1;
        pins = {cs_n, act_n, ras_n, cas_n, we_n};
        chk("cmd",  32'(pins), 32'(m_cmd));
        chk("addr", 32'(addr), 32'(m_addr));
        chk("bgba", 32'({bg, ba}), 32'(0));
        chk("busy", 32'(maint_busy), 32'(m_active));
        chk("idle", 32'(rw_idle), 32'(m_idle));
        chk("err",  32'(err_underflow), 32'(m_err));
        if (pins !== CMD_NOP) begin
            log_cmd.push_back(pins); log_cyc.push_back(cyc); log_addr.push_back(addr);
        end
        if (prev_busy && !maint_busy) fall_cyc = cyc;
        prev_busy = maint_busy;
        refresh_rdy = 0; mrs_update_rdy = 0; rw_issue = 0; rw_retire = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        log_cmd.delete(); log_cyc.delete(); log_addr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] t3_exp[4];
        int c0, r;
        t3_exp = '{CMD_PREA, CMD_REF, CMD_PREA, CMD_MRS};
        model_reset();

        // Reset state
        run(2);
        chk("rst_busy", 32'(maint_busy), 32'(0));
        chk("rst_idle", 32'(rw_idle), 32'(0));
        reset_n = 1;
        run(2);

        // Test 1: single refresh
        clear_log();
        refresh_rdy = 1; cycle(); c0 = cyc;
        run(30);
        chk("t1_n", 32'(log_cmd.size()), 32'(2));
        if (log_cmd.size() >= 2) begin
            chk("t1_prea_lat", 32'(log_cyc[0] - c0), 32'(1));
            chk("t1_ref_cmd", 32'(log_cmd[1]), 32'(CMD_REF));
            chk("t1_ref_lat", 32'(log_cyc[1] - log_cyc[0]), 32'(tRP));
            chk("t1_busy_end", 32'(fall_cyc - log_cyc[1]), 32'(tRFC));
        end

        // Test 2: mode-register write
        clear_log();
        mrs_update_rdy = 1; mrs_update_cmd = MRS_WIDTH'(16'h0A34); cycle();
        mrs_update_cmd = '0;
        run(20);
        chk("t2_n", 32'(log_cmd.size()), 32'(2));
        if (log_cmd.size() >= 2) begin
            chk("t2_mrs_cmd", 32'(log_cmd[1]), 32'(CMD_MRS));
            chk("t2_mrs_addr", 32'(log_addr[1]), 32'h0A34);
            chk("t2_busy_end", 32'(fall_cyc - log_cyc[1]), 32'(tMOD));
        end

        // Test 3: refresh and MRS together
        clear_log();
        refresh_rdy = 1; mrs_update_rdy = 1; mrs_update_cmd = MRS_WIDTH'(16'h0123); cycle();
        run(45);
        chk("t3_n", 32'(log_cmd.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < log_cmd.size()) chk($sformatf("t3_cmd%0d", i), 32'(log_cmd[i]), 32'(t3_exp[i]));

        // Test 4: outstanding traffic blocks maintenance
        clear_log();
        rw_proc = 1;
        for (int i = 0; i < 3; i++) begin rw_issue = 1; cycle(); end
        rw_proc = 0; refresh_rdy = 1; cycle();
        run(8);
        rw_issue = 1; rw_retire = 1; cycle();
        run(3);
        rw_retire = 1; cycle();
        rw_retire = 1; cycle();
        run(3);
        chk("t4_blocked", 32'(log_cmd.size()), 32'(0));
        rw_retire = 1; cycle(); r = cyc;
        run(3);
        chk("t4_n", 32'(log_cmd.size() > 0), 32'(1));
        if (log_cmd.size() > 0) begin
            chk("t4_prea", 32'(log_cmd[0]), 32'(CMD_PREA));
            chk("t4_prea_lat", 32'(log_cyc[0] - r), 32'(1));
        end
        run(25);

        // Saturation: 20 issues then 15 retires drains a 4-bit counter
        rw_proc = 1;
        for (int i = 0; i < 20; i++) begin rw_issue = 1; cycle(); end
        for (int i = 0; i < 15; i++) begin rw_retire = 1; cycle(); end
        rw_proc = 0;
        run(2);
        chk("sat_idle", 32'(rw_idle), 32'(1));
        chk("sat_err", 32'(err_underflow), 32'(0));

        // Test 5: retire at zero
        rw_retire = 1; cycle();
        run(2);
        chk("t5_err", 32'(err_underflow), 32'(1));
        chk("t5_idle", 32'(rw_idle), 32'(1));

        // Test 6: reset during tRFC
        clear_log();
        refresh_rdy = 1; cycle();
        run(8);
        chk("t6_in_trfc", 32'(maint_busy), 32'(1));
        #2 reset_n = 0;
        #1;
        chk("t6_pins_nop", 32'({cs_n, act_n, ras_n, cas_n, we_n}), 32'(CMD_NOP));
        chk("t6_busy", 32'(maint_busy), 32'(0));
        chk("t6_err", 32'(err_underflow), 32'(0));
        chk("t6_idle", 32'(rw_idle), 32'(0));
        model_reset();
        prev_busy = 0;
        run(2);
        reset_n = 1;
        chk("t6_idle_pre_edge", 32'(rw_idle), 32'(0));
        clear_log();
        run(20);
        chk("t6_no_cmd", 32'(log_cmd.size()), 32'(0));

        // Randomised traffic and maintenance requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rw_proc = ~rw_proc;
            refresh_rdy    = ($urandom_range(0, 29) == 0);
            mrs_update_rdy = ($urandom_range(0, 39) == 0);
            mrs_update_cmd = MRS_WIDTH'($urandom);
            rw_issue       = rw_proc && ($urandom_range(0, 2) == 0);
            rw_retire      = (m_cnt > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
